// File: rtl/serial_channel_arbiter_pkg.sv
// Shared encodings for the serial channel arbiter and the downstream detector path.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    ID   = 3'd2,
    PAY  = 3'd3,
    GAP  = 3'd4
  } state_t;

  localparam logic [3:0] DEFAULT_PREAMBLE = 4'b1101;

endpackage

// File: rtl/serial_channel_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, with wrap.
module rr_pick #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             valid,
  output logic [ID_W-1:0]  idx
);

  logic [ID_W-1:0] cand;

  // Walk from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      cand = ptr + ID_W'(i);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/serial_channel_arbiter.sv
// Round-robin arbiter framing one shared serial channel: preamble, source id, payload, gap.
//   state | meaning
//   IDLE  | waiting for any request, pick next source round-robin
//   PRE   | sending preamble MSB first
//   ID    | sending granted source index MSB first
//   PAY   | passing granted source payload through, len+1 bits
//   GAP   | one idle tick, frame_done, advance round-robin pointer
module serial_channel_arbiter
  import serial_pkg::*;
#(
  parameter int                 N_SRC    = 4,
  parameter int                 ID_W     = 2,
  parameter int                 LEN_W    = 4,
  parameter int                 PRE_W    = 4,
  parameter logic [PRE_W-1:0]   PREAMBLE = DEFAULT_PREAMBLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [N_SRC-1:0] req,
  input  logic [N_SRC-1:0] ser_in,
  input  logic [LEN_W-1:0] pay_len,
  output logic [N_SRC-1:0] gnt,
  output logic             pay_shift,
  output logic             ser_out,
  output logic             ser_out_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  sel;
  logic [LEN_W-1:0] bcnt;
  logic [LEN_W-1:0] len;

  logic             pick_valid;
  logic [ID_W-1:0]  pick_idx;
  logic [PRE_W-1:0] pre_sh;
  logic [ID_W-1:0]  id_sh;
  logic [N_SRC-1:0] sel_onehot;

  rr_pick #(.N_SRC(N_SRC), .ID_W(ID_W)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
      bcnt  <= '0;
      len   <= '0;
    end else if (clk_en) begin
      case (state)
        IDLE: if (pick_valid) begin
          sel   <= pick_idx;
          len   <= pay_len;
          bcnt  <= '0;
          state <= PRE;
        end
        PRE: if (bcnt == LEN_W'(PRE_W - 1)) begin
          bcnt  <= '0;
          state <= ID;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
        ID: if (bcnt == LEN_W'(ID_W - 1)) begin
          bcnt  <= '0;
          state <= PAY;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
        // Terminal compare before increment, so len = max never wraps bcnt.
        PAY: if (bcnt == len) begin
          state <= GAP;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
        GAP: begin
          ptr   <= sel + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pre_sh     = PREAMBLE << bcnt;
  assign id_sh      = sel << bcnt;
  assign sel_onehot = N_SRC'(1) << sel;

  always_comb begin
    gnt           = '0;
    pay_shift     = 1'b0;
    ser_out       = 1'b0;
    ser_out_valid = 1'b0;
    frame_start   = 1'b0;
    frame_done    = 1'b0;
    busy          = (state != IDLE);
    case (state)
      PRE: begin
        ser_out       = pre_sh[PRE_W-1];
        ser_out_valid = 1'b1;
        gnt           = sel_onehot;
        frame_start   = (bcnt == '0);
      end
      ID: begin
        ser_out       = id_sh[ID_W-1];
        ser_out_valid = 1'b1;
        gnt           = sel_onehot;
      end
      PAY: begin
        ser_out       = ser_in[sel];
        ser_out_valid = 1'b1;
        gnt           = sel_onehot;
        pay_shift     = clk_en;
      end
      GAP: frame_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serial_channel_arbiter.sv
// Bench for serial_channel_arbiter: vector table, corner sequences, randomized run vs frame-list model.
module tb_serial_channel_arbiter;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] ser_in = '0;
  logic [3:0] pay_len = '0;
  logic [3:0] gnt;
  logic       pay_shift, ser_out, ser_out_valid, frame_start, frame_done, busy;

  always #5 clk = ~clk;

  serial_channel_arbiter dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req(req), .ser_in(ser_in),
    .pay_len(pay_len), .gnt(gnt), .pay_shift(pay_shift), .ser_out(ser_out),
    .ser_out_valid(ser_out_valid), .frame_start(frame_start),
    .frame_done(frame_done), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a frame is a list of expected ticks; kind 1=preamble 2=id 3=payload 4=gap.
  typedef struct { int kind; bit b; bit first; } ent_t;
  ent_t        fq[$];
  int          msel = 0;
  int          mptr = 0;
  logic [31:0] data [N];
  int          pos  [N];
  logic [3:0]  pre_bits = 4'b1101;

  typedef struct { logic [3:0] g; bit so, v, fs, fd, bz, ps; } vec_t;
  vec_t tab [11];

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] dutv();
    return {gnt, ser_out, ser_out_valid, frame_start, frame_done, busy, pay_shift};
  endfunction

  task automatic drive_ser();
    for (int s = 0; s < N; s++) ser_in[s] = data[s][pos[s] % 32];
  endtask

  task automatic build_frame(int s);
    ent_t e;
    msel = s;
    mptr = (s + 1) % N;
    for (int i = 0; i < 4; i++) begin
      e.kind = 1; e.b = pre_bits[3-i]; e.first = (i == 0); fq.push_back(e);
    end
    for (int i = 0; i < 2; i++) begin
      e.kind = 2; e.b = bit'((s >> (1 - i)) & 1); e.first = 0; fq.push_back(e);
    end
    for (int i = 0; i <= int'(pay_len); i++) begin
      e.kind = 3; e.b = 0; e.first = 0; fq.push_back(e);
    end
    e.kind = 4; e.b = 0; e.first = 0; fq.push_back(e);
  endtask

  task automatic model_edge();
    bit found;
    int s;
    if (!clk_en) return;
    if (fq.size() == 0) begin
      found = 0;
      for (int i = 0; i < N; i++) begin
        s = (mptr + i) % N;
        if (!found && req[s]) begin
          found = 1;
          build_frame(s);
        end
      end
    end else begin
      if (fq[0].kind == 3) pos[msel]++;
      void'(fq.pop_front());
    end
  endtask

  task automatic model_check();
    logic [3:0] eg;
    bit eso, ev, efs, efd, eb, eps;
    eg = '0; eso = 0; ev = 0; efs = 0; efd = 0; eb = 0; eps = 0;
    if (fq.size() != 0) begin
      eb  = 1;
      efs = fq[0].first;
      efd = (fq[0].kind == 4);
      if (fq[0].kind != 4) begin
        eg = 4'(1 << msel);
        ev = 1;
        eso = (fq[0].kind == 3) ? ser_in[msel] : fq[0].b;
      end
      eps = (fq[0].kind == 3) && clk_en;
    end
    cmp("model", dutv(), {eg, eso, ev, efs, efd, eb, eps});
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    drive_ser();
    #1;
    model_check();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fq.delete();
    mptr = 0;
    msel = 0;
    for (int s = 0; s < N; s++) pos[s] = 0;
    drive_ser();
    #1;
    cmp("reset", dutv(), 10'd0);
    #2;
    rst = 1'b0;
  endtask

  task automatic set_vec(int i, logic [3:0] g, bit so, v, fs, fd, bz, ps);
    tab[i].g = g; tab[i].so = so; tab[i].v = v; tab[i].fs = fs;
    tab[i].fd = fd; tab[i].bz = bz; tab[i].ps = ps;
  endtask

  function automatic logic [9:0] tabv(int i);
    return {tab[i].g, tab[i].so, tab[i].v, tab[i].fs, tab[i].fd, tab[i].bz, tab[i].ps & clk_en};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int vcs[$];
    int vc, pc, idx;
    bit done;

    // Source 0 payload 1,0,1 for the reference frame.
    for (int s = 0; s < N; s++) data[s] = 32'h0;
    data[0] = 32'b101;
    set_vec(0,  4'b0001, 1, 1, 1, 0, 1, 0);
    set_vec(1,  4'b0001, 1, 1, 0, 0, 1, 0);
    set_vec(2,  4'b0001, 0, 1, 0, 0, 1, 0);
    set_vec(3,  4'b0001, 1, 1, 0, 0, 1, 0);
    set_vec(4,  4'b0001, 0, 1, 0, 0, 1, 0);
    set_vec(5,  4'b0001, 0, 1, 0, 0, 1, 0);
    set_vec(6,  4'b0001, 1, 1, 0, 0, 1, 1);
    set_vec(7,  4'b0001, 0, 1, 0, 0, 1, 1);
    set_vec(8,  4'b0001, 1, 1, 0, 0, 1, 1);
    set_vec(9,  4'b0000, 0, 0, 0, 1, 1, 0);
    set_vec(10, 4'b0000, 0, 0, 0, 0, 0, 0);

    // Reference frame, clk_en always high.
    do_reset();
    req = 4'b0001; pay_len = 4'd2; clk_en = 1'b1;
    for (int r = 0; r < 11; r++) begin
      tick();
      cmp("s1_vec", dutv(), tabv(r));
      req = '0;
    end

    // Same frame with clk_en 1 in 4: each bit held for four clocks.
    do_reset();
    req = 4'b0001; pay_len = 4'd2;
    for (int r = 0; r < 11; r++) begin
      clk_en = 1'b1;
      tick();
      cmp("s3_vec", dutv(), tabv(r));
      req = '0;
      clk_en = 1'b0;
      for (int h = 0; h < 3; h++) begin
        tick();
        cmp("s3_hold", dutv(), tabv(r));
      end
    end

    // All requesting: grant order and frame length.
    do_reset();
    req = 4'hf; pay_len = 4'd0; clk_en = 1'b1; vc = 0;
    for (int k = 0; k < 60 && order.size() < 5; k++) begin
      tick();
      if (ser_out_valid) vc++;
      if (frame_done) begin vcs.push_back(vc); vc = 0; end
      if (frame_start) begin
        idx = -1;
        for (int j = 0; j < N; j++) if (gnt[j]) idx = j;
        order.push_back(idx);
      end
    end
    cmp("s2_frames", order.size(), 5);
    for (int i = 0; i < order.size(); i++) cmp("s2_order", order[i], i % 4);
    cmp("s2_done_cnt", vcs.size(), 4);
    for (int i = 0; i < vcs.size(); i++) cmp("s2_valid_ticks", vcs[i], 7);
    req = '0;

    // Maximum length, pay_len changed after grant.
    do_reset();
    req = 4'b0100; pay_len = 4'd15; clk_en = 1'b1;
    tick();
    pay_len = 4'd3; req = '0;
    pc = 0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      tick();
      if (pay_shift) pc++;
      if (frame_done) done = 1;
    end
    cmp("s4_done", done, 1);
    cmp("s4_pay_ticks", pc, 16);

    // Reset in the middle of source 1's payload, then regrant from ptr 0.
    do_reset();
    req = 4'b0010; pay_len = 4'd5; clk_en = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    cmp("s5_in_pay", {gnt, pay_shift}, {4'b0010, 1'b1});
    do_reset();
    req = 4'b0110;
    tick();
    cmp("s5_regrant", gnt, 4'b0010);
    req = '0;

    // Request dropped mid-payload: frame still completes.
    do_reset();
    req = 4'b1000; pay_len = 4'd5; clk_en = 1'b1; pc = 0; done = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (pay_shift) pc++;
    end
    req = '0;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      if (pay_shift) pc++;
      if (frame_done) done = 1;
    end
    cmp("s6_done", done, 1);
    cmp("s6_pay_ticks", pc, 6);

    // Randomized traffic against the frame-list model.
    for (int s = 0; s < N; s++) data[s] = $urandom;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      req     = 4'($urandom_range(0, 15));
      clk_en  = ($urandom_range(0, 3) != 0);
      pay_len = 4'($urandom_range(0, 15));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_channel_arbiter.md
# serial_channel_arbiter

Round-robin controller that shares one serial output channel among `N_SRC` serial sources in the Lab 2 serial datapath. It grants one requester at a time and emits a framed bit stream on that channel: a fixed preamble, the granted source index, then a counted payload passed through from the granted source. The frame layout matches what the existing serial detector/counter path consumes. All sequencing advances only on clock-enable ticks.

## Interface
Parameters:
- `N_SRC`, 4: number of requesters (power of two, ≥2).
- `ID_W`, 2: source index width, equal to log2(`N_SRC`).
- `LEN_W`, 4: payload-length field width.
- `PRE_W`, 4: preamble width.
- `PREAMBLE`, 4'b1101: preamble bits, sent MSB first.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `clk_en` in 1: bit-rate enable; state and counters advance only on edges where it is 1.
- `req` in N_SRC: per-source request, level.
- `ser_in` in N_SRC: per-source serial payload bit.
- `pay_len` in LEN_W: payload length code, sampled at grant; the frame carries `pay_len`+1 bits.
- `gnt` out N_SRC: one-hot grant, held from grant through end of payload.
- `pay_shift` out 1: `clk_en` AND in PAY; the granted source advances its payload bit on this edge.
- `ser_out` out 1: channel serial bit.
- `ser_out_valid` out 1: high in PRE, ID and PAY.
- `frame_start` out 1: one-tick pulse, first PRE tick.
- `frame_done` out 1: one-tick pulse, GAP tick.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, PRE, ID, PAY, GAP. The bit counter `bcnt` (LEN_W bits) is shared across states.
- IDLE: if any `req` bit is set, select the first set bit searching upward from `ptr` with wrap-around. Latch `sel`, latch `len`←`pay_len`, set `gnt`, clear `bcnt`, and go to PRE. Otherwise remain in IDLE.
- PRE: `ser_out`=`PREAMBLE[PRE_W-1-bcnt]`. When `bcnt`=`PRE_W`-1, clear `bcnt` and go to ID.
- ID: `ser_out`=`sel[ID_W-1-bcnt]`, MSB first. When `bcnt`=`ID_W`-1, clear `bcnt` and go to PAY.
- PAY: `ser_out`=`ser_in[sel]` (combinational pass-through) and `pay_shift`=`clk_en`. When `bcnt`=`len`, go to GAP.
- GAP: `ser_out`=0, `ser_out_valid`=0, `gnt`=0, `frame_done`=1. Set `ptr`←`sel`+1 (mod `N_SRC`) and go to IDLE.
- `req` is sampled only in IDLE. Dropping `req` mid-frame is ignored and the frame completes. A source still requesting after its frame loses priority to any other requester.
- `pay_len` changes after grant have no effect on the current frame.
- `clk_en`=0 freezes all state, and all Moore outputs hold.
- Reset values: state=IDLE, `ptr`=0, `sel`=0, `bcnt`=0, `len`=0. All outputs are 0, including `ser_out` (never high-Z).

## Timing
- All outputs except `ser_out` in PAY and `pay_shift` are Moore outputs decoded from registered state.
- Latency from `req` being seen in IDLE on an enabled edge to the first preamble bit: 1 tick.
- Frame length: `PRE_W`+`ID_W`+`len`+1 valid ticks, then 1 GAP tick. The earliest next grant is the tick after GAP, so IDLE lasts at least 1 tick between frames.
- With `len`=15, `bcnt` reaches 15 without overflowing the LEN_W-bit counter.
- `rst` asserted mid-frame: outputs go to 0 immediately and the arbiter restarts from `ptr`=0.

## Structure
- Shared package `serial_pkg`: state encoding constants (IDLE=3'd0, PRE=1, ID=2, PAY=3, GAP=4) and the default `PREAMBLE`, so the detector side uses the same values.
- One sub-module is natural: `rr_pick`, a combinational round-robin selector (`req`, `ptr` → `valid`, `idx`).

## Test plan
- After reset, `req`=4'b0001, `pay_len`=2, `ser_in[0]` stream 1,0,1, `clk_en` always 1. Required: `ser_out`=1,1,0,1, 0,0, 1,0,1, then GAP. `frame_start` on tick 1, `frame_done` on tick 10, `pay_shift` high for 3 ticks.
- `req`=4'b1111 held, `pay_len`=0. Required: grant order 0,1,2,3,0. Each frame is 7 valid ticks, and the ID field reads 00,01,10,11.
- `clk_en` pulsing 1 in 4 during a frame. Required: each bit held for 4 clocks, `pay_shift` only on enabled edges, and output sequence identical to the first scenario.
- `pay_len`=15 with `req[2]`. Required: exactly 16 PAY ticks and no counter wrap. A `pay_len` change mid-frame is ignored.
- `rst` pulsed during PAY of source 1. Required: `gnt`, `ser_out_valid` and `busy` drop immediately. With `req`=4'b0110 afterwards, source 1 is granted (search from `ptr`=0).
- `req[3]` deasserted mid-PAY. Required: the frame still completes with full length and `frame_done` pulses.
